game_state_tx: RTL and testbench

//  Transmit end of the multiplayer game-state link. Once per video frame it snapshots
//  the ball position and both scores produced by ball_control. It streams them as a

---
 rtl/game_state_tx.sv | 125 ++++++++++++
 tb/tb_game_state_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_tx.sv
// Game-state link transmitter: once per frame, snapshots the ball position and both
// scores and streams them as a 7-byte packet over a valid/ready byte interface.
// Packet: SYNC, x[10:8], x[7:0], y[10:8], y[7:0], {p1,p2}, XOR of bytes 1..5.
module game_state_tx #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned OVR_W     = 8
) (
  input  logic             clk65MHz,
  input  logic             rst_n,
  input  logic             end_of_frame,
  input  logic             link_en,
  input  logic [10:0]      x_pos_of_ball,
  input  logic [10:0]      y_pos_of_ball,
  input  logic [3:0]       points_player_1,
  input  logic [3:0]       points_player_2,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic [OVR_W-1:0] overrun_cnt
);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e           state_q;
  logic [2:0]       idx_q;
  logic [10:0]      x_q;
  logic [10:0]      y_q;
  logic [3:0]       p1_q;
  logic [3:0]       p2_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic             busy_q;
  logic [OVR_W-1:0] ovr_q;

  logic             fire;
  logic             xfer;
  logic [2:0]       idx_nx;
  logic [7:0]       b1, b2, b3, b4, b5, b6;
  logic [7:0]       next_byte_d;

  assign fire   = end_of_frame && link_en;
  assign xfer   = tx_valid_q && tx_ready;
  assign idx_nx = idx_q + 3'd1;

  // Packet bytes derived from the held snapshot; selects the byte following idx_q.
  always_comb begin
    b1 = {5'b0, x_q[10:8]};
    b2 = x_q[7:0];
    b3 = {5'b0, y_q[10:8]};
    b4 = y_q[7:0];
    b5 = {p1_q, p2_q};
    b6 = b1 ^ b2 ^ b3 ^ b4 ^ b5;
    next_byte_d = SYNC_BYTE;
    case (idx_nx)
      3'd1:    next_byte_d = b1;
      3'd2:    next_byte_d = b2;
      3'd3:    next_byte_d = b3;
      3'd4:    next_byte_d = b4;
      3'd5:    next_byte_d = b5;
      3'd6:    next_byte_d = b6;
      default: next_byte_d = SYNC_BYTE;
    endcase
  end

  // Packet FSM with registered outputs, snapshot capture and saturating overrun count.
  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fire) begin
            x_q        <= x_pos_of_ball;
            y_q        <= y_pos_of_ball;
            p1_q       <= points_player_1;
            p2_q       <= points_player_2;
            idx_q      <= '0;
            tx_data_q  <= SYNC_BYTE;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          // A frame arriving while busy is dropped, even on the final-byte edge.
          if (fire && (ovr_q != '1)) begin
            ovr_q <= ovr_q + OVR_W'(1);
          end
          if (xfer) begin
            if (idx_q == 3'd6) begin
              idx_q      <= '0;
              tx_data_q  <= '0;
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              idx_q     <= idx_nx;
              tx_data_q <= next_byte_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_game_state_tx.sv
// Directed-plus-random bench for game_state_tx against a packet model built from
// plain arithmetic on the snapshot values.
module tb_game_state_tx;

  logic        clk65MHz = 1'b0;
  logic        rst_n;
  logic        end_of_frame;
  logic        link_en;
  logic [10:0] x_pos_of_ball;
  logic [10:0] y_pos_of_ball;
  logic [3:0]  points_player_1;
  logic [3:0]  points_player_2;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [7:0]  overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int ovr_exp  = 0;

  game_state_tx #(.SYNC_BYTE(8'hA5), .OVR_W(8)) dut (
    .clk65MHz        (clk65MHz),
    .rst_n           (rst_n),
    .end_of_frame    (end_of_frame),
    .link_en         (link_en),
    .x_pos_of_ball   (x_pos_of_ball),
    .y_pos_of_ball   (y_pos_of_ball),
    .points_player_1 (points_player_1),
    .points_player_2 (points_player_2),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .busy            (busy),
    .overrun_cnt     (overrun_cnt)
  );

  always #5 clk65MHz = ~clk65MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte i of the packet lives in bits [8*i +: 8].
  function automatic logic [55:0] model_pkt(input int x, input int y, input int p1, input int p2);
    int b[7];
    logic [55:0] r;
    b[0] = 'hA5;
    b[1] = x / 256;
    b[2] = x % 256;
    b[3] = y / 256;
    b[4] = y % 256;
    b[5] = p1 * 16 + p2;
    b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
    r = '0;
    for (int i = 0; i < 7; i++) r[8*i +: 8] = 8'(b[i]);
    return r;
  endfunction

  task automatic scramble_inputs();
    x_pos_of_ball   = 11'($urandom);
    y_pos_of_ball   = 11'($urandom);
    points_player_1 = 4'($urandom);
    points_player_2 = 4'($urandom);
  endtask

  // Called at a negedge; the trigger edge is the next posedge.
  task automatic start_frame(input int x, input int y, input int p1, input int p2);
    x_pos_of_ball   = 11'(x);
    y_pos_of_ball   = 11'(y);
    points_player_1 = 4'(p1);
    points_player_2 = 4'(p2);
    link_en         = 1'b1;
    end_of_frame    = 1'b1;
    @(negedge clk65MHz);
    end_of_frame    = 1'b0;
    scramble_inputs();
  endtask

  // mode 0: ready always 1; 1: ready 1,0,0 repeating; 2: random ready.
  task automatic collect(input string tag, input logic [55:0] pkt, input int mode,
                         input int drop_link_at, input bit eof_at_last, input int stop_after);
    int       k = 0;
    int       vcyc = 0;
    bit       hold = 0;
    bit       rdy;
    logic [7:0] hold_data = '0;
    for (int cyc = 0; cyc < 300 && k < stop_after; cyc++) begin
      if (hold) begin
        check({tag, "_hold_data"}, tx_data, hold_data);
        check({tag, "_hold_valid"}, tx_valid, 1);
      end
      if (tx_valid) begin
        vcyc++;
        check({tag, "_busy"}, busy, 1);
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom);
      tx_ready = rdy;
      if (eof_at_last && k == 6 && tx_valid && rdy) begin
        end_of_frame = 1'b1;
        if (ovr_exp < 255) ovr_exp++;
      end
      if (tx_valid && rdy) begin
        check($sformatf("%s_b%0d", tag, k), tx_data, pkt[8*k +: 8]);
        k++;
        if (k == drop_link_at) link_en = 1'b0;
      end
      hold      = tx_valid && !rdy;
      hold_data = tx_data;
      @(negedge clk65MHz);
      end_of_frame = 1'b0;
      scramble_inputs();
    end
    check({tag, "_timeout"}, (k >= stop_after), 1);
    if (stop_after == 7) begin
      check({tag, "_end_valid"}, tx_valid, 0);
      check({tag, "_end_busy"}, busy, 0);
      check({tag, "_ovr"}, overrun_cnt, ovr_exp);
      if (mode == 0) check({tag, "_valid_cycles"}, vcyc, 7);
    end
  endtask

  initial begin
    int rx, ry, r1, r2;
    // 1. reset with random inputs
    rst_n = 1'b0;
    tx_ready = 1'b1;
    link_en = 1'b1;
    end_of_frame = 1'b1;
    scramble_inputs();
    #1;
    check("rst_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", tx_data, 0);
    check("rst_ovr", overrun_cnt, 0);
    repeat (3) @(negedge clk65MHz);
    check("rst_hold_valid", tx_valid, 0);
    end_of_frame = 1'b0;
    rst_n = 1'b1;
    @(negedge clk65MHz);
    check("idle_valid", tx_valid, 0);

    // 2. directed packet at full throughput
    start_frame(600, 300, 3, 7);
    collect("basic", model_pkt(600, 300, 3, 7), 0, -1, 1'b0, 7);

    // 3. backpressure 1,0,0 pattern; a frame on the final-byte edge is dropped
    start_frame(600, 300, 3, 7);
    collect("bp", model_pkt(600, 300, 3, 7), 1, -1, 1'b1, 7);
    repeat (3) @(negedge clk65MHz);
    check("bp_no_restart", tx_valid, 0);

    // 4. overrun while stalled
    tx_ready = 1'b0;
    start_frame(1234, 777, 9, 2);
    end_of_frame = 1'b1;
    link_en = 1'b1;
    @(negedge clk65MHz);
    end_of_frame = 1'b0;
    if (ovr_exp < 255) ovr_exp++;
    check("ovr_one", overrun_cnt, ovr_exp);
    check("ovr_hold_sync", tx_data, 8'hA5);
    collect("ovr_pkt", model_pkt(1234, 777, 9, 2), 0, -1, 1'b0, 7);
    tx_ready = 1'b0;
    start_frame(5, 2047, 15, 0);
    end_of_frame = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk65MHz);
      if (ovr_exp < 255) ovr_exp++;
    end
    end_of_frame = 1'b0;
    check("ovr_sat", overrun_cnt, 255);
    check("ovr_sat_model", overrun_cnt, ovr_exp);
    collect("ovr_sat_pkt", model_pkt(5, 2047, 15, 0), 2, -1, 1'b0, 7);

    // 5. link disabled, then link dropped mid-packet
    link_en = 1'b0;
    end_of_frame = 1'b1;
    @(negedge clk65MHz);
    end_of_frame = 1'b0;
    repeat (2) @(negedge clk65MHz);
    check("nolink_valid", tx_valid, 0);
    check("nolink_ovr", overrun_cnt, ovr_exp);
    start_frame(1000, 20, 1, 14);
    collect("linkdrop", model_pkt(1000, 20, 1, 14), 0, 3, 1'b0, 7);
    end_of_frame = 1'b1;
    @(negedge clk65MHz);
    end_of_frame = 1'b0;
    @(negedge clk65MHz);
    check("linkdrop_idle", tx_valid, 0);
    link_en = 1'b1;

    // 6. async reset after b3
    start_frame(333, 444, 5, 6);
    collect("abort", model_pkt(333, 444, 5, 6), 0, -1, 1'b0, 4);
    #2 rst_n = 1'b0;
    #1;
    ovr_exp = 0;
    check("abort_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_data", tx_data, 0);
    check("abort_ovr", overrun_cnt, 0);
    repeat (3) @(negedge clk65MHz);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk65MHz);
    check("abort_no_resume", tx_valid, 0);
    rx = int'($urandom_range(0, 2047));
    ry = int'($urandom_range(0, 2047));
    r1 = int'($urandom_range(0, 15));
    r2 = int'($urandom_range(0, 15));
    start_frame(rx, ry, r1, r2);
    collect("after_abort", model_pkt(rx, ry, r1, r2), 0, -1, 1'b0, 7);

    // random packets with random backpressure
    for (int n = 0; n < 8; n++) begin
      rx = int'($urandom_range(0, 2047));
      ry = int'($urandom_range(0, 2047));
      r1 = int'($urandom_range(0, 15));
      r2 = int'($urandom_range(0, 15));
      start_frame(rx, ry, r1, r2);
      collect($sformatf("rnd%0d", n), model_pkt(rx, ry, r1, r2), 2, -1, 1'($urandom), 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
